data_mem_sized: RTL and testbench

Parametrised, wait-state-capable byte-addressable data memory for the vcpu1 load/store stage. It supports byte, halfword and word accesses in big-endian order, with sign or zero extension on loads. A req/ready/done handshake and a configurable wait-state counter let the core be exercised against slow memory. Misaligned, out-of-range and reserved-size accesses complete with an error flag and leave memory unchanged.

---
 rtl/data_mem_sized_if.sv | 36 +++
 rtl/data_mem_sized.sv | 177 +++++++++++++++++
 tb/tb_data_mem_sized.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_sized_if.sv
// ---------------------------------------------------------------------------
// data_mem_sized_if
// Load/store bus between the vcpu1 core (master) and data_mem_sized (slave).
//   req    core -> mem  access request, sampled only while ready=1
//   wr     core -> mem  1: store, 0: load
//   size   core -> mem  00 byte, 01 halfword, 10 word, 11 reserved
//   sign   core -> mem  loads only: 1 sign-extend, 0 zero-extend
//   addr   core -> mem  byte address
//   wdata  core -> mem  store data, right-aligned
//   ready  mem -> core  request can be accepted this cycle
//   done   mem -> core  one-cycle completion pulse
//   rdata  mem -> core  load result, valid with done
//   err    mem -> core  error status, valid with done
// ---------------------------------------------------------------------------
interface data_mem_sized_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic        sign;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, wr, size, sign, addr, wdata,
    input  ready, done, rdata, err
  );

  modport slave (
    input  req, wr, size, sign, addr, wdata,
    output ready, done, rdata, err
  );
endinterface

// File: rtl/data_mem_sized.sv
// ---------------------------------------------------------------------------
// data_mem_sized
// Byte-addressable big-endian data memory with byte/half/word accesses,
// sign/zero-extended loads and a programmable number of wait states.
// Misaligned, out-of-range and reserved-size accesses complete with err=1,
// rdata=0 and leave the memory untouched.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    data_mem_sized_if.slave (req/wr/size/sign/addr/wdata in,
//          ready/done/rdata/err out)
// Parameters:
//   DEPTH_BYTES  memory size in bytes, multiple of 4
//   WAIT_CYCLES  extra busy cycles before each access executes, 0..255
// ---------------------------------------------------------------------------
module data_mem_sized #(
  parameter int DEPTH_BYTES = 8192,
  parameter int WAIT_CYCLES = 0
) (
  input logic             clk,
  input logic             rst_n,
  data_mem_sized_if.slave bus
);

  localparam int AW = $clog2(DEPTH_BYTES);
  typedef logic [AW-1:0] idx_t;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q;
  logic        lat_wr;
  logic [1:0]  lat_size;
  logic        lat_sign;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic        done_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic [7:0]  mem [DEPTH_BYTES];

  logic        accept;
  logic        exec;

  assign accept = (state_q == IDLE) && bus.req;
  assign exec   = (state_q == BUSY) && (cnt_q == 8'd0);

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.req) state_d = BUSY;
      BUSY: if (cnt_q == 8'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.ready = (state_q == IDLE);
    bus.done  = done_q;
    bus.rdata = rdata_q;
    bus.err   = err_q;
  end

  // Capture the access on acceptance; later bus changes cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 8'd0;
      lat_wr    <= 1'b0;
      lat_size  <= 2'b00;
      lat_sign  <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
    end else if (accept) begin
      cnt_q     <= 8'(WAIT_CYCLES);
      lat_wr    <= bus.wr;
      lat_size  <= bus.size;
      lat_sign  <= bus.sign;
      lat_addr  <= bus.addr;
      lat_wdata <= bus.wdata;
    end else if (state_q == BUSY && cnt_q != 8'd0) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  // ---------------- Access decode ----------------
  logic [1:0]  last_off;
  logic [32:0] last_byte;
  logic        misalign;
  logic        acc_err;

  always_comb begin
    last_off = 2'd0;
    misalign = 1'b0;
    unique case (lat_size)
      2'b00: last_off = 2'd0;
      2'b01: begin last_off = 2'd1; misalign = lat_addr[0];          end
      2'b10: begin last_off = 2'd3; misalign = (lat_addr[1:0] != 2'b00); end
      default: last_off = 2'd0;
    endcase
    // 33-bit sum so an address near 2^32 cannot wrap into range.
    last_byte = {1'b0, lat_addr} + {31'd0, last_off};
    acc_err   = (lat_size == 2'b11) || misalign ||
                (last_byte >= 33'(DEPTH_BYTES));
  end

  idx_t i0, i1, i2, i3;
  assign i0 = lat_addr[AW-1:0];
  assign i1 = i0 + idx_t'(1);
  assign i2 = i0 + idx_t'(2);
  assign i3 = i0 + idx_t'(3);

  // ---------------- Storage ----------------
  // NOTE: the array has no reset; clearing it would need a port per byte.
  // Contents are undefined until written.
  always_ff @(posedge clk) begin
    if (exec && lat_wr && !acc_err) begin
      unique case (lat_size)
        2'b00: mem[i0] <= lat_wdata[7:0];
        2'b01: begin
          mem[i0] <= lat_wdata[15:8];
          mem[i1] <= lat_wdata[7:0];
        end
        2'b10: begin
          mem[i0] <= lat_wdata[31:24];
          mem[i1] <= lat_wdata[23:16];
          mem[i2] <= lat_wdata[15:8];
          mem[i3] <= lat_wdata[7:0];
        end
        default: ;
      endcase
    end
  end

  // Big-endian load assembly with extension from the first (MSB) byte.
  logic [31:0] load_val;
  logic        ext;

  always_comb begin
    ext      = lat_sign & mem[i0][7];
    load_val = 32'd0;
    unique case (lat_size)
      2'b00:   load_val = {{24{ext}}, mem[i0]};
      2'b01:   load_val = {{16{ext}}, mem[i0], mem[i1]};
      2'b10:   load_val = {mem[i0], mem[i1], mem[i2], mem[i3]};
      default: load_val = 32'd0;
    endcase
  end

  // rdata/err update only on execute edges and hold between completions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      done_q <= exec;
      if (exec) begin
        err_q   <= acc_err;
        rdata_q <= (acc_err || lat_wr) ? 32'd0 : load_val;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_sized.sv
// ---------------------------------------------------------------------------
// tb_data_mem_sized
// Directed bench: u0 has no wait states, u3 has WAIT_CYCLES=3.
// ---------------------------------------------------------------------------
module tb_data_mem_sized;

  localparam int DEPTH = 8192;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  data_mem_sized_if m0 ();
  data_mem_sized_if m3 ();

  data_mem_sized #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(0)) u0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (m0.slave)
  );

  data_mem_sized #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(3)) u3 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (m3.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access on u0, returns the completion values.
  task automatic acc0(input logic w, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic e);
    int n;
    @(negedge clk);
    m0.req = 1'b1; m0.wr = w; m0.size = sz; m0.sign = sg;
    m0.addr = a;   m0.wdata = wd;
    @(negedge clk);
    m0.req = 1'b0;
    n = 0;
    while (m0.done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", {31'd0, m0.done}, 32'd1);
    rd = m0.rdata;
    e  = m0.err;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        e;
    logic [31:0] va [3];
    logic [31:0] aa [3];

    rst_n = 1'b0;
    m0.req = 0; m0.wr = 0; m0.size = 0; m0.sign = 0; m0.addr = 0; m0.wdata = 0;
    m3.req = 0; m3.wr = 0; m3.size = 0; m3.sign = 0; m3.addr = 0; m3.wdata = 0;

    // Reset state
    #12;
    check("rst_ready", {31'd0, m0.ready}, 32'd1);
    check("rst_done",  {31'd0, m0.done},  32'd0);
    check("rst_rdata", m0.rdata,          32'd0);
    check("rst_err",   {31'd0, m0.err},   32'd0);
    check("rst_ready3", {31'd0, m3.ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Word store then big-endian loads
    acc0(1, 2'b10, 0, 32'h10, 32'h11223344, rd, e);
    check("st_w_rdata", rd, 32'd0);
    check("st_w_err", {31'd0, e}, 32'd0);
    acc0(0, 2'b10, 0, 32'h10, 32'h0, rd, e);
    check("ld_w_10", rd, 32'h11223344);
    check("ld_w_err", {31'd0, e}, 32'd0);
    acc0(0, 2'b00, 0, 32'h10, 32'h0, rd, e);
    check("ld_b_10", rd, 32'h00000011);
    acc0(0, 2'b01, 1, 32'h12, 32'h0, rd, e);
    check("ld_h_12", rd, 32'h00003344);

    // Byte store into a known word, sign/zero extension
    acc0(1, 2'b10, 0, 32'h20, 32'hAABBCCDD, rd, e);
    acc0(1, 2'b00, 0, 32'h21, 32'hFFFFFF80, rd, e);
    check("st_b_err", {31'd0, e}, 32'd0);
    acc0(0, 2'b00, 1, 32'h21, 32'h0, rd, e);
    check("ld_b_sx", rd, 32'hFFFFFF80);
    acc0(0, 2'b00, 0, 32'h21, 32'h0, rd, e);
    check("ld_b_zx", rd, 32'h00000080);
    acc0(0, 2'b10, 1, 32'h20, 32'h0, rd, e);
    check("ld_w_20", rd, 32'hAA80CCDD);
    acc0(0, 2'b01, 1, 32'h20, 32'h0, rd, e);
    check("ld_h_sx", rd, 32'hFFFFAA80);
    repeat (3) @(negedge clk);
    check("hold_rdata", m0.rdata, 32'hFFFFAA80);
    check("hold_done", {31'd0, m0.done}, 32'd0);

    // Error cases
    acc0(1, 2'b10, 0, 32'h100, 32'h55667788, rd, e);
    acc0(1, 2'b10, 0, 32'h102, 32'hDEADBEEF, rd, e);
    check("e_wmis_err", {31'd0, e}, 32'd1);
    check("e_wmis_rd", rd, 32'd0);
    acc0(0, 2'b10, 0, 32'h100, 32'h0, rd, e);
    check("e_wmis_keep", rd, 32'h55667788);
    acc0(0, 2'b01, 0, 32'h7, 32'h0, rd, e);
    check("e_hmis_err", {31'd0, e}, 32'd1);
    check("e_hmis_rd", rd, 32'd0);
    acc0(1, 2'b11, 0, 32'h10, 32'hFFFFFFFF, rd, e);
    check("e_sz3_err", {31'd0, e}, 32'd1);
    acc0(0, 2'b10, 0, 32'h10, 32'h0, rd, e);
    check("e_sz3_keep", rd, 32'h11223344);
    acc0(1, 2'b10, 0, DEPTH - 2, 32'h12345678, rd, e);
    check("e_top_err", {31'd0, e}, 32'd1);
    acc0(0, 2'b00, 0, DEPTH, 32'h0, rd, e);
    check("e_oor_err", {31'd0, e}, 32'd1);
    acc0(1, 2'b00, 0, DEPTH - 1, 32'h000000A5, rd, e);
    check("top_b_err", {31'd0, e}, 32'd0);
    acc0(1, 2'b10, 0, DEPTH - 4, 32'h0BADF00D, rd, e);
    check("top_w_err", {31'd0, e}, 32'd0);
    acc0(0, 2'b10, 0, DEPTH - 4, 32'h0, rd, e);
    check("top_w_ld", rd, 32'h0BADF00D);

    // Wait states on u3: req held high throughout
    @(negedge clk);
    m3.req = 1; m3.wr = 1; m3.size = 2'b10; m3.sign = 0;
    m3.addr = 32'h40; m3.wdata = 32'hCAFEF00D;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ws_st_ready", {31'd0, m3.ready}, 32'd0);
      check("ws_st_done",  {31'd0, m3.done},  32'd0);
    end
    @(negedge clk);
    check("ws_st_done1", {31'd0, m3.done},  32'd1);
    check("ws_st_rdy1",  {31'd0, m3.ready}, 32'd1);
    m3.wr = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ws_ld_ready", {31'd0, m3.ready}, 32'd0);
      check("ws_ld_done",  {31'd0, m3.done},  32'd0);
    end
    @(negedge clk);
    check("ws_ld_done1", {31'd0, m3.done}, 32'd1);
    check("ws_ld_rdata", m3.rdata, 32'hCAFEF00D);
    m3.req = 0;
    @(negedge clk);
    check("ws_idle_done", {31'd0, m3.done}, 32'd0);

    // Back-to-back store/load on u0, inputs changed while busy
    va[0] = 32'h01020304; aa[0] = 32'h80;
    va[1] = 32'hF0E0D0C0; aa[1] = 32'h84;
    va[2] = 32'h5A5AA5A5; aa[2] = 32'h88;
    @(negedge clk);
    m0.req = 1; m0.wr = 1; m0.size = 2'b10; m0.sign = 0;
    m0.addr = aa[0]; m0.wdata = va[0];
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("b2b_st_busy", {31'd0, m0.done}, 32'd0);
      m0.wr = 0; m0.wdata = 32'hFFFFFFFF;
      @(negedge clk);
      check("b2b_st_done", {31'd0, m0.done}, 32'd1);
      check("b2b_st_err",  {31'd0, m0.err},  32'd0);
      @(negedge clk);
      check("b2b_ld_busy", {31'd0, m0.done}, 32'd0);
      if (k < 2) begin
        m0.wr = 1; m0.addr = aa[k+1]; m0.wdata = va[k+1];
      end else begin
        m0.req = 0;
      end
      @(negedge clk);
      check("b2b_ld_done",  {31'd0, m0.done}, 32'd1);
      check("b2b_ld_rdata", m0.rdata, va[k]);
    end

    // Reset while busy aborts a store
    @(negedge clk);
    m0.req = 1; m0.wr = 1; m0.size = 2'b10; m0.addr = 32'h10; m0.wdata = 32'hFFFFFFFF;
    @(negedge clk);
    m0.req = 0;
    check("abort_busy", {31'd0, m0.ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ready", {31'd0, m0.ready}, 32'd1);
    check("abort_done",  {31'd0, m0.done},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    acc0(0, 2'b10, 0, 32'h10, 32'h0, rd, e);
    check("abort_keep", rd, 32'h11223344);

    // Reset in the done cycle clears done at once
    @(negedge clk);
    m0.req = 1; m0.wr = 0; m0.size = 2'b10; m0.addr = 32'h20;
    @(negedge clk);
    m0.req = 0;
    @(negedge clk);
    check("dc_done", {31'd0, m0.done}, 32'd1);
    check("dc_rdata", m0.rdata, 32'hAA80CCDD);
    rst_n = 1'b0;
    #1;
    check("dc_rst_done",  {31'd0, m0.done}, 32'd0);
    check("dc_rst_rdata", m0.rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
